// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges jump redirect, load-use, multi-cycle EX hold and generic
// hold requests into per-register stall/flush vectors plus the PC redirect.
module pipe_ctrl #(
    parameter int unsigned NUM_STAGES   = 5,
    parameter int unsigned EX_STAGE     = 2,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned NUM_HOLD_SRC = 2,
    parameter logic [4*NUM_HOLD_SRC-1:0] HOLD_STAGE = {4'd3, 4'd1},
    parameter int unsigned MC_W         = 6,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    jump_en_i,
    input  logic [ADDR_W-1:0]       jump_addr_i,
    input  logic                    ex_is_load_i,
    input  logic                    ex_rd_we_i,
    input  logic [4:0]              ex_rd_waddr_i,
    input  logic [4:0]              id_rs1_addr_i,
    input  logic [4:0]              id_rs2_addr_i,
    input  logic [1:0]              id_rs_use_i,
    input  logic                    mc_start_i,
    input  logic [MC_W-1:0]         mc_cycles_i,
    input  logic [NUM_HOLD_SRC-1:0] hold_req_i,
    output logic [NUM_STAGES-1:0]   stall_o,
    output logic [NUM_STAGES-1:0]   flush_o,
    output logic                    jump_en_o,
    output logic [ADDR_W-1:0]       jump_addr_o,
    output logic                    busy_o,
    output logic [CNT_W-1:0]        stall_cnt_o,
    output logic [CNT_W-1:0]        jump_cnt_o
);

    // One extra bit so that s+1 never wraps when compared against register indices.
    localparam int unsigned SW = $clog2(NUM_STAGES) + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MC_BUSY   = 2'd1,
        JUMP_PEND = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [MC_W-1:0]     mc_cnt_q, mc_cnt_d;
    logic                pend_q, pend_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic [CNT_W-1:0]    stall_cnt_q, jump_cnt_q;

    logic                load_use_c;
    logic                mc_start_ok_c;
    logic                mc_hold_c;
    logic                hold_any_c;
    logic [SW-1:0]       depth_c;
    logic                jump_src_c;
    logic [ADDR_W-1:0]   jump_tgt_c;
    logic                issue_c;
    logic                capture_c;

    // Hazard sources
    always_comb begin
        load_use_c = ex_is_load_i & ex_rd_we_i & (ex_rd_waddr_i != 5'd0) &
                     ((id_rs_use_i[0] & (id_rs1_addr_i == ex_rd_waddr_i)) |
                      (id_rs_use_i[1] & (id_rs2_addr_i == ex_rd_waddr_i)));
        mc_start_ok_c = (state_q != MC_BUSY) & mc_start_i & (mc_cycles_i != '0);
        mc_hold_c     = (state_q == MC_BUSY) | mc_start_ok_c;
    end

    // Stall depth: highest register index any active hold needs frozen
    always_comb begin
        hold_any_c = 1'b0;
        depth_c    = '0;
        if (load_use_c) begin
            hold_any_c = 1'b1;
            depth_c    = SW'(1);
        end
        if (mc_hold_c) begin
            hold_any_c = 1'b1;
            if (SW'(EX_STAGE) > depth_c) depth_c = SW'(EX_STAGE);
        end
        for (int k = 0; k < int'(NUM_HOLD_SRC); k++) begin
            if (hold_req_i[k]) begin
                hold_any_c = 1'b1;
                if (SW'(HOLD_STAGE[k*4 +: 4]) > depth_c) depth_c = SW'(HOLD_STAGE[k*4 +: 4]);
            end
        end
    end

    // A pending target always wins over a fresh jump_en_i from the same held instruction
    always_comb begin
        jump_src_c = pend_q | jump_en_i;
        jump_tgt_c = pend_q ? pend_addr_q : jump_addr_i;
        issue_c    = jump_src_c & (depth_c < SW'(EX_STAGE));
        capture_c  = jump_en_i & ~pend_q & ~issue_c;
    end

    // Stall/flush vectors and redirect
    always_comb begin
        stall_o     = '0;
        flush_o     = '0;
        jump_en_o   = 1'b0;
        jump_addr_o = '0;
        if (rst) begin
            flush_o = '1;
            flush_o[0] = 1'b0;
        end else begin
            if (hold_any_c) begin
                for (int i = 0; i < int'(NUM_STAGES); i++) begin
                    if (SW'(i) <= depth_c) stall_o[i] = 1'b1;
                    if (i > 0 && SW'(i) == depth_c + SW'(1)) flush_o[i] = 1'b1;
                end
            end
            if (issue_c) begin
                jump_en_o   = 1'b1;
                jump_addr_o = jump_tgt_c;
                for (int i = 0; i < int'(NUM_STAGES); i++) begin
                    if (i >= 1 && i <= int'(EX_STAGE)) flush_o[i] = 1'b1;
                    if (i < int'(EX_STAGE)) stall_o[i] = 1'b0;
                end
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        mc_cnt_d    = mc_cnt_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        if (capture_c) begin
            pend_d      = 1'b1;
            pend_addr_d = jump_addr_i;
        end
        if (issue_c) pend_d = 1'b0;
        case (state_q)
            MC_BUSY: begin
                mc_cnt_d = mc_cnt_q - MC_W'(1);
                if (mc_cnt_q <= MC_W'(1)) state_d = pend_d ? JUMP_PEND : IDLE;
            end
            default: begin
                if (mc_start_ok_c && mc_cycles_i > MC_W'(1)) begin
                    mc_cnt_d = mc_cycles_i - MC_W'(1);
                    state_d  = MC_BUSY;
                end else begin
                    state_d = pend_d ? JUMP_PEND : IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mc_cnt_q    <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            stall_cnt_q <= '0;
            jump_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            mc_cnt_q    <= mc_cnt_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            if (stall_o[0] && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (jump_en_o && jump_cnt_q != '1) jump_cnt_q <= jump_cnt_q + CNT_W'(1);
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign stall_cnt_o = stall_cnt_q;
    assign jump_cnt_o  = jump_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl with default parameters.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        ex_is_load_i;
    logic        ex_rd_we_i;
    logic [4:0]  ex_rd_waddr_i;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic [1:0]  id_rs_use_i;
    logic        mc_start_i;
    logic [5:0]  mc_cycles_i;
    logic [1:0]  hold_req_i;
    logic [4:0]  stall_o;
    logic [4:0]  flush_o;
    logic        jump_en_o;
    logic [31:0] jump_addr_o;
    logic        busy_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] jump_cnt_o;

    int checks = 0;
    int errors = 0;

    pipe_ctrl dut (
        .clk(clk), .rst(rst),
        .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .ex_is_load_i(ex_is_load_i), .ex_rd_we_i(ex_rd_we_i), .ex_rd_waddr_i(ex_rd_waddr_i),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i), .id_rs_use_i(id_rs_use_i),
        .mc_start_i(mc_start_i), .mc_cycles_i(mc_cycles_i), .hold_req_i(hold_req_i),
        .stall_o(stall_o), .flush_o(flush_o), .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o),
        .busy_o(busy_o), .stall_cnt_o(stall_cnt_o), .jump_cnt_o(jump_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        jump_en_i = 0; jump_addr_i = '0; ex_is_load_i = 0; ex_rd_we_i = 0; ex_rd_waddr_i = '0;
        id_rs1_addr_i = '0; id_rs2_addr_i = '0; id_rs_use_i = '0;
        mc_start_i = 0; mc_cycles_i = '0; hold_req_i = '0;
    endtask

    task automatic test_reset();
        rst = 1; clear_inputs();
        step();
        checks++; if (stall_o !== 5'b00000) begin errors++; $display("FAIL rst_stall got %b exp 00000", stall_o); end
        checks++; if (flush_o !== 5'b11110) begin errors++; $display("FAIL rst_flush got %b exp 11110", flush_o); end
        checks++; if (jump_en_o !== 1'b0) begin errors++; $display("FAIL rst_jump got %b exp 0", jump_en_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy_o); end
        rst = 0;
        #1;
        checks++; if (flush_o !== 5'b00000) begin errors++; $display("FAIL idle_flush got %b exp 00000", flush_o); end
        checks++; if (stall_cnt_o !== 32'd0 || jump_cnt_o !== 32'd0) begin errors++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", stall_cnt_o, jump_cnt_o); end
    endtask

    task automatic test_load_use();
        ex_is_load_i = 1; ex_rd_we_i = 1; ex_rd_waddr_i = 5'd5; id_rs1_addr_i = 5'd5; id_rs_use_i = 2'b01;
        #1;
        checks++; if (stall_o !== 5'b00011) begin errors++; $display("FAIL lu_stall got %b exp 00011", stall_o); end
        checks++; if (flush_o !== 5'b00100) begin errors++; $display("FAIL lu_flush got %b exp 00100", flush_o); end
        step();
        clear_inputs();
        #1;
        checks++; if (stall_o !== 5'b00000) begin errors++; $display("FAIL lu_release got %b exp 00000", stall_o); end
        checks++; if (stall_cnt_o !== 32'd1) begin errors++; $display("FAIL lu_cnt got %0d exp 1", stall_cnt_o); end
    endtask

    task automatic test_no_hazard();
        ex_is_load_i = 1; ex_rd_we_i = 1; ex_rd_waddr_i = 5'd0; id_rs1_addr_i = 5'd0; id_rs_use_i = 2'b01;
        #1;
        checks++; if (stall_o !== 5'b00000 || flush_o !== 5'b00000) begin errors++; $display("FAIL x0_load got %b/%b exp 00000/00000", stall_o, flush_o); end
        ex_rd_waddr_i = 5'd7; id_rs1_addr_i = 5'd3; id_rs2_addr_i = 5'd7; id_rs_use_i = 2'b01;
        #1;
        checks++; if (stall_o !== 5'b00000) begin errors++; $display("FAIL rs2_unused got %b exp 00000", stall_o); end
        id_rs_use_i = 2'b10;
        #1;
        checks++; if (stall_o !== 5'b00011) begin errors++; $display("FAIL rs2_used got %b exp 00011", stall_o); end
        clear_inputs();
        step();
    endtask

    task automatic test_multicycle();
        mc_start_i = 1; mc_cycles_i = 6'd4;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (stall_o !== 5'b00111 || flush_o !== 5'b01000) begin errors++; $display("FAIL mc_cyc%0d got %b/%b exp 00111/01000", c, stall_o, flush_o); end
            checks++; if (busy_o !== (c > 0)) begin errors++; $display("FAIL mc_busy%0d got %b exp %b", c, busy_o, (c > 0)); end
            step();
            mc_start_i = 0; mc_cycles_i = '0;
        end
        #1;
        checks++; if (stall_o !== 5'b00000 || busy_o !== 1'b0) begin errors++; $display("FAIL mc_end got %b/%b exp 00000/0", stall_o, busy_o); end
        checks++; if (stall_cnt_o !== 32'd5) begin errors++; $display("FAIL mc_cnt got %0d exp 5", stall_cnt_o); end
    endtask

    task automatic test_jump();
        jump_en_i = 1; jump_addr_i = 32'h80;
        #1;
        checks++; if (jump_en_o !== 1'b1 || jump_addr_o !== 32'h80) begin errors++; $display("FAIL jmp_issue got %b/%h exp 1/80", jump_en_o, jump_addr_o); end
        checks++; if (flush_o !== 5'b00110 || stall_o !== 5'b00000) begin errors++; $display("FAIL jmp_flush got %b/%b exp 00110/00000", flush_o, stall_o); end
        step();
        clear_inputs();
        #1;
        checks++; if (jump_cnt_o !== 32'd1) begin errors++; $display("FAIL jmp_cnt got %0d exp 1", jump_cnt_o); end
        checks++; if (jump_en_o !== 1'b0 || jump_addr_o !== 32'h0) begin errors++; $display("FAIL jmp_idle got %b/%h exp 0/0", jump_en_o, jump_addr_o); end
        // Jump overrides a simultaneous load-use stall
        jump_en_i = 1; jump_addr_i = 32'h200;
        ex_is_load_i = 1; ex_rd_we_i = 1; ex_rd_waddr_i = 5'd9; id_rs1_addr_i = 5'd9; id_rs_use_i = 2'b01;
        #1;
        checks++; if (jump_en_o !== 1'b1 || stall_o !== 5'b00000 || flush_o !== 5'b00110) begin errors++; $display("FAIL jmp_lu got %b/%b/%b exp 1/00000/00110", jump_en_o, stall_o, flush_o); end
        step();
        clear_inputs();
    endtask

    task automatic test_jump_pending();
        hold_req_i = 2'b10; jump_en_i = 1; jump_addr_i = 32'h40;
        #1;
        checks++; if (jump_en_o !== 1'b0) begin errors++; $display("FAIL pend_noissue got %b exp 0", jump_en_o); end
        checks++; if (stall_o !== 5'b01111 || flush_o !== 5'b10000) begin errors++; $display("FAIL pend_hold got %b/%b exp 01111/10000", stall_o, flush_o); end
        step();
        jump_en_i = 0;
        #1;
        checks++; if (busy_o !== 1'b1 || jump_en_o !== 1'b0) begin errors++; $display("FAIL pend_wait got %b/%b exp 1/0", busy_o, jump_en_o); end
        step();
        jump_en_i = 1; jump_addr_i = 32'h99;
        step();
        hold_req_i = 2'b00;
        #1;
        checks++; if (jump_en_o !== 1'b1 || jump_addr_o !== 32'h40) begin errors++; $display("FAIL pend_issue got %b/%h exp 1/40", jump_en_o, jump_addr_o); end
        checks++; if (flush_o !== 5'b00110) begin errors++; $display("FAIL pend_flush got %b exp 00110", flush_o); end
        step();
        clear_inputs();
        #1;
        checks++; if (busy_o !== 1'b0 || jump_cnt_o !== 32'd3) begin errors++; $display("FAIL pend_done got %b/%0d exp 0/3", busy_o, jump_cnt_o); end
        checks++; if (stall_cnt_o !== 32'd8) begin errors++; $display("FAIL pend_scnt got %0d exp 8", stall_cnt_o); end
        hold_req_i = 2'b01;
        #1;
        checks++; if (stall_o !== 5'b00011 || flush_o !== 5'b00100) begin errors++; $display("FAIL hold0 got %b/%b exp 00011/00100", stall_o, flush_o); end
        clear_inputs();
        step();
    endtask

    task automatic test_jump_during_mc();
        mc_start_i = 1; mc_cycles_i = 6'd2; jump_en_i = 1; jump_addr_i = 32'h100;
        #1;
        checks++; if (jump_en_o !== 1'b0 || stall_o !== 5'b00111) begin errors++; $display("FAIL jmc_c0 got %b/%b exp 0/00111", jump_en_o, stall_o); end
        step();
        clear_inputs();
        #1;
        checks++; if (jump_en_o !== 1'b0 || stall_o !== 5'b00111) begin errors++; $display("FAIL jmc_c1 got %b/%b exp 0/00111", jump_en_o, stall_o); end
        step();
        checks++; if (jump_en_o !== 1'b1 || jump_addr_o !== 32'h100 || busy_o !== 1'b1) begin errors++; $display("FAIL jmc_issue got %b/%h/%b exp 1/100/1", jump_en_o, jump_addr_o, busy_o); end
        step();
        checks++; if (busy_o !== 1'b0 || jump_en_o !== 1'b0) begin errors++; $display("FAIL jmc_done got %b/%b exp 0/0", busy_o, jump_en_o); end
    endtask

    task automatic test_reset_in_mc();
        mc_start_i = 1; mc_cycles_i = 6'd5;
        step();
        clear_inputs();
        step();
        rst = 1;
        #1;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rmc_busy_pre got %b exp 1", busy_o); end
        checks++; if (stall_o !== 5'b00000 || flush_o !== 5'b11110) begin errors++; $display("FAIL rmc_during got %b/%b exp 00000/11110", stall_o, flush_o); end
        step();
        rst = 0;
        #1;
        checks++; if (busy_o !== 1'b0 || stall_o !== 5'b00000) begin errors++; $display("FAIL rmc_after got %b/%b exp 0/00000", busy_o, stall_o); end
        checks++; if (stall_cnt_o !== 32'd0 || jump_cnt_o !== 32'd0) begin errors++; $display("FAIL rmc_cnt got %0d/%0d exp 0/0", stall_cnt_o, jump_cnt_o); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_multicycle();
        test_jump();
        test_jump_pending();
        test_jump_during_mc();
        test_reset_in_mc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
